// File: rtl/clk_div_prog_if.sv
// Control and status bundle for clk_div_prog: run enables, restart, config writes,
// and the divided clock / tick / pending / error outputs.
interface clk_div_prog_if #(
  parameter int NCH = 3,
  parameter int W   = 31
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] en;
  logic           sync_restart;
  logic           wr_en;
  logic [CW-1:0]  wr_ch;
  logic [W-1:0]   wr_div;
  logic [W-1:0]   wr_hi;
  logic [NCH-1:0] clko;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pend;
  logic           wr_err;

  modport master (
    output en, sync_restart, wr_en, wr_ch, wr_div, wr_hi,
    input  clko, tick, pend, wr_err
  );

  modport slave (
    input  en, sync_restart, wr_en, wr_ch, wr_div, wr_hi,
    output clko, tick, pend, wr_err
  );
endinterface

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with shadowed period/high-time config
// that is applied only at each channel's period boundary (glitch-free outputs).
module clk_div_prog #(
  parameter int NCH     = 3,
  parameter int W       = 31,
  parameter int DEF_DIV = 50000000
) (
  input  logic          clki,
  input  logic          rst,
  clk_div_prog_if.slave bus
);
  localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);
  localparam logic [W-1:0] DEF_HI_W  = (DEF_DIV / 2 < 1) ? W'(1) : W'(DEF_DIV / 2);

  logic [W-1:0]   r_cnt   [NCH];
  logic [W-1:0]   r_div_a [NCH];
  logic [W-1:0]   r_hi_a  [NCH];
  logic [W-1:0]   r_div_s [NCH];
  logic [W-1:0]   r_hi_s  [NCH];
  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] r_run;
  logic [NCH-1:0] r_clko;
  logic [NCH-1:0] r_tick;
  logic           r_wr_err;

  logic [W-1:0]   w_cnt_nxt [NCH];
  logic [W-1:0]   w_div_nxt [NCH];
  logic [W-1:0]   w_hi_nxt  [NCH];
  logic [NCH-1:0] w_wrap;
  logic [NCH-1:0] w_apply;
  logic [NCH-1:0] w_hit;
  logic           w_legal;

  // A channel restarts its period on restart, while disabled, on its first enabled
  // cycle, or at the natural wrap; each of these is a point where shadow may apply.
  always_comb begin
    w_legal = bus.wr_en && (int'(bus.wr_ch) < NCH) && (bus.wr_div >= W'(2)) &&
              (bus.wr_hi >= W'(1)) && (bus.wr_hi < bus.wr_div);
    w_wrap  = '0;
    w_apply = '0;
    w_hit   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_wrap[i]    = bus.sync_restart || !bus.en[i] || !r_run[i] ||
                     (r_cnt[i] == r_div_a[i] - W'(1));
      w_apply[i]   = r_pend[i] && w_wrap[i];
      w_hit[i]     = w_legal && (int'(bus.wr_ch) == i);
      w_cnt_nxt[i] = w_wrap[i] ? '0 : r_cnt[i] + W'(1);
      w_div_nxt[i] = w_apply[i] ? r_div_s[i] : r_div_a[i];
      w_hi_nxt[i]  = w_apply[i] ? r_hi_s[i]  : r_hi_a[i];
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i]   <= '0;
        r_div_a[i] <= DEF_DIV_W;
        r_hi_a[i]  <= DEF_HI_W;
        r_div_s[i] <= DEF_DIV_W;
        r_hi_s[i]  <= DEF_HI_W;
      end
      r_pend   <= '0;
      r_run    <= '0;
      r_clko   <= '0;
      r_tick   <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= bus.wr_en && !w_legal;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i]   <= w_cnt_nxt[i];
        r_div_a[i] <= w_div_nxt[i];
        r_hi_a[i]  <= w_hi_nxt[i];
        if (w_hit[i]) begin
          r_div_s[i] <= bus.wr_div;
          r_hi_s[i]  <= bus.wr_hi;
        end
        // Pending from before this edge is consumed; a write on this edge re-arms it.
        r_pend[i] <= w_hit[i] || (r_pend[i] && !w_apply[i]);
        r_run[i]  <= bus.en[i];
        r_clko[i] <= bus.en[i] && (w_cnt_nxt[i] < w_hi_nxt[i]);
        r_tick[i] <= bus.en[i] && (w_cnt_nxt[i] == '0);
      end
    end
  end

  assign bus.clko   = r_clko;
  assign bus.tick   = r_tick;
  assign bus.pend   = r_pend;
  assign bus.wr_err = r_wr_err;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a cycle-level phase model checks every output
// each cycle, and literal expectations pin the key scenarios.
module tb_clk_div_prog;
  localparam int NCH = 3;
  localparam int W   = 8;
  localparam int DEF = 10;

  logic clki = 1'b0;
  logic rst;
  always #5 clki = ~clki;

  clk_div_prog_if #(.NCH(NCH), .W(W)) bus ();
  clk_div_prog #(.NCH(NCH), .W(W), .DEF_DIV(DEF)) dut (
    .clki (clki),
    .rst  (rst),
    .bus  (bus)
  );

  int nvec   = 0;
  int nerr   = 0;
  int cyc_no = 0;

  // Model: phase within the current period, plus active/shadow config per channel.
  int       m_div [NCH];
  int       m_hi  [NCH];
  int       m_sdiv[NCH];
  int       m_shi [NCH];
  int       m_ph  [NCH];
  bit [2:0] m_run;
  bit [2:0] m_pend;
  bit [2:0] m_clko;
  bit [2:0] m_tick;
  bit       m_err;

  task automatic model_edge();
    bit legal;
    bit due;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_div[c] = DEF; m_hi[c] = DEF / 2; m_sdiv[c] = DEF; m_shi[c] = DEF / 2; m_ph[c] = 0;
      end
      m_run = '0; m_pend = '0; m_clko = '0; m_tick = '0; m_err = 1'b0;
    end else begin
      legal = bus.wr_en && (bus.wr_ch < NCH) && (bus.wr_div >= 2) &&
              (bus.wr_hi >= 1) && (bus.wr_hi < bus.wr_div);
      m_err = bus.wr_en && !legal;
      for (int c = 0; c < NCH; c++) begin
        due = 1'b0;
        if (!bus.en[c]) begin
          m_ph[c] = 0; m_run[c] = 1'b0; due = 1'b1;
        end else if (bus.sync_restart || !m_run[c]) begin
          m_ph[c] = 0; m_run[c] = 1'b1; due = 1'b1;
        end else begin
          m_ph[c] = m_ph[c] + 1;
          if (m_ph[c] == m_div[c]) begin
            m_ph[c] = 0; due = 1'b1;
          end
        end
        if (due && m_pend[c]) begin
          m_div[c] = m_sdiv[c]; m_hi[c] = m_shi[c]; m_pend[c] = 1'b0;
        end
        if (legal && bus.wr_ch == c) begin
          m_sdiv[c] = int'(bus.wr_div); m_shi[c] = int'(bus.wr_hi); m_pend[c] = 1'b1;
        end
        m_tick[c] = bus.en[c] && (m_ph[c] == 0);
        m_clko[c] = bus.en[c] && (m_ph[c] < m_hi[c]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clki);
      model_edge();
      cyc_no++;
      #1;
      chk("model_clko", {29'd0, bus.clko}, {29'd0, m_clko});
      chk("model_tick", {29'd0, bus.tick}, {29'd0, m_tick});
      chk("model_pend", {29'd0, bus.pend}, {29'd0, m_pend});
      chk("model_wr_err", {31'd0, bus.wr_err}, {31'd0, m_err});
    end
  endtask

  task automatic wr(input int ch, input int dv, input int hi);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 2'(ch);
    bus.wr_div = W'(dv);
    bus.wr_hi  = W'(hi);
    cyc(1);
    bus.wr_en  = 1'b0;
  endtask

  int bad_ch [4] = '{0, 0, 0, 3};
  int bad_div[4] = '{1, 6, 6, 6};
  int bad_hi [4] = '{1, 0, 6, 2};

  initial begin
    rst = 1'b1;
    bus.en = '0; bus.sync_restart = 1'b0; bus.wr_en = 1'b0;
    bus.wr_ch = '0; bus.wr_div = '0; bus.wr_hi = '0;
    cyc(2);
    chk("rst_clko", bus.clko, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_pend", bus.pend, 0);

    // Default run: 10-cycle period, 5 high, ticks at 0/10/20.
    rst = 1'b0;
    bus.en = 3'b001;
    for (int k = 0; k < 22; k++) begin
      cyc(1);
      chk("dflt_tick0", bus.tick[0], (k % 10 == 0));
      chk("dflt_clko0", bus.clko[0], (k % 10 < 5));
      chk("dflt_ch12", bus.clko[2:1], 0);
    end

    // Mid-period write at cnt=3.
    cyc(2);
    wr(0, 4, 1);
    chk("mid_pend_set", bus.pend[0], 1);
    chk("mid_clko_old", bus.clko[0], 1);
    cyc(5);
    chk("mid_pend_hold", bus.pend[0], 1);
    chk("mid_clko_low", bus.clko[0], 0);
    cyc(1);
    chk("mid_apply_tick", bus.tick[0], 1);
    chk("mid_apply_clko", bus.clko[0], 1);
    chk("mid_pend_clr", bus.pend[0], 0);
    cyc(1);
    chk("mid_hi1", bus.clko[0], 0);
    cyc(3);
    chk("mid_div4_tick", bus.tick[0], 1);

    // Restore 10/5, then write exactly on the boundary edge.
    wr(0, 10, 5);
    cyc(3);
    chk("rest_pend_clr", bus.pend[0], 0);
    chk("rest_tick", bus.tick[0], 1);
    cyc(9);
    chk("rest_div10", bus.tick[0], 0);
    wr(0, 4, 1);
    chk("bnd_tick", bus.tick[0], 1);
    chk("bnd_pend", bus.pend[0], 1);
    chk("bnd_old_hi", bus.clko[0], 1);
    cyc(9);
    chk("bnd_pend_wait", bus.pend[0], 1);
    cyc(1);
    chk("bnd_apply_tick", bus.tick[0], 1);
    chk("bnd_pend_clr", bus.pend[0], 0);
    cyc(1);
    chk("bnd_hi1", bus.clko[0], 0);
    cyc(3);
    chk("bnd_div4_tick", bus.tick[0], 1);

    // Illegal writes.
    for (int j = 0; j < 4; j++) begin
      wr(bad_ch[j], bad_div[j], bad_hi[j]);
      chk("ill_err_pulse", bus.wr_err, 1);
      chk("ill_pend", bus.pend, 0);
      cyc(1);
      chk("ill_err_width", bus.wr_err, 0);
    end

    // Restart alignment with divs 10, 7, 3.
    wr(0, 10, 5);
    wr(1, 7, 3);
    wr(2, 3, 1);
    bus.en = 3'b111;
    cyc(17);
    bus.sync_restart = 1'b1;
    cyc(1);
    bus.sync_restart = 1'b0;
    chk("rs_tick_all", bus.tick, 3'b111);
    chk("rs_clko_all", bus.clko, 3'b111);
    cyc(2);
    chk("rs_tick_none", bus.tick, 0);
    cyc(1);
    chk("rs_tick_ch2", bus.tick, 3'b100);
    chk("rs_clko", bus.clko, 3'b101);

    // Disable ch1 during high time, write while disabled, re-enable.
    cyc(5);
    chk("dis_pre_hi", bus.clko[1], 1);
    bus.en = 3'b101;
    cyc(1);
    chk("dis_clko", bus.clko[1], 0);
    chk("dis_tick", bus.tick[1], 0);
    wr(1, 5, 2);
    chk("dis_pend", bus.pend[1], 1);
    cyc(1);
    chk("dis_apply", bus.pend[1], 0);
    bus.en = 3'b111;
    cyc(1);
    chk("en_tick", bus.tick[1], 1);
    chk("en_clko", bus.clko[1], 1);
    cyc(1);
    chk("en_hi2", bus.clko[1], 1);
    cyc(1);
    chk("en_lo", bus.clko[1], 0);
    cyc(3);
    chk("en_div5_tick", bus.tick[1], 1);

    // Reset mid-operation with ch2 pending.
    wr(2, 6, 2);
    chk("rm_pend", bus.pend[2], 1);
    rst = 1'b1;
    cyc(1);
    chk("rm_clko", bus.clko, 0);
    chk("rm_tick", bus.tick, 0);
    chk("rm_pend_clr", bus.pend, 0);
    cyc(1);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      chk("rm_tick2", bus.tick[2], (k % 10 == 0));
      chk("rm_clko2", bus.clko[2], (k % 10 < 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_no);
    $fatal(1, "watchdog");
  end
endmodule
